// File: rtl/sawtooth_phase_counter_if.sv
// Purpose: control/ramp bundle between the control registers, the phase counter and the amplitude stage.
// Latency: n/a (wires only); the slave side registers every output.
// Backpressure: none; the consumer must accept one ramp value per cycle.
interface sawtooth_phase_counter_if #(
   parameter int N_FRAC    = 7,
   parameter int N_ACC_EXT = 8,
   parameter int N_DIV     = 8
);
   localparam int W = N_FRAC + 1 + N_ACC_EXT;

   logic              enable_i;
   logic              sync_i;
   logic [W-1:0]      freq_word_i;
   logic [N_DIV-1:0]  divider_i;
   logic [N_FRAC:0]   counter_value_o;
   logic              next_counter_value_strobe_o;
   logic              wrap_o;

   // Control side: drives run/sync/frequency/divider, observes the ramp.
   modport master (
      output enable_i, sync_i, freq_word_i, divider_i,
      input  counter_value_o, next_counter_value_strobe_o, wrap_o
   );

   // Phase counter side.
   modport slave (
      input  enable_i, sync_i, freq_word_i, divider_i,
      output counter_value_o, next_counter_value_strobe_o, wrap_o
   );
endinterface

// File: rtl/sawtooth_phase_counter.sv
// Purpose: prescaled phase accumulator producing a signed sawtooth ramp with a valid strobe and wrap flag.
// Latency: 1 cycle from the tick/sync edge to strobe and new value; all outputs registered.
// Backpressure: none; a new value may appear every cycle (divider 0 or sync held).
module sawtooth_phase_counter #(
   parameter int N_FRAC    = 7,
   parameter int N_ACC_EXT = 8,
   parameter int N_DIV     = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   sawtooth_phase_counter_if.slave       phase_if
);
   localparam int W = N_FRAC + 1 + N_ACC_EXT;
   localparam logic [N_FRAC:0] RAMP_MIN = {1'b1, {N_FRAC{1'b0}}};

   logic [W-1:0]     acc_q,      acc_d;
   logic [N_DIV-1:0] div_cnt_q,  div_cnt_d;
   logic [N_FRAC:0]  value_q,    value_d;
   logic             strobe_q,   strobe_d;
   logic             wrap_q,     wrap_d;
   logic [W:0]       acc_sum;
   logic             tick;

   // Next-state: sync restarts phase and prescaler, otherwise a tick advances the phase.
   always_comb begin
      acc_d     = acc_q;
      div_cnt_d = div_cnt_q;
      value_d   = value_q;
      strobe_d  = 1'b0;
      wrap_d    = 1'b0;
      acc_sum   = {1'b0, acc_q} + {1'b0, phase_if.freq_word_i};
      tick      = phase_if.enable_i && (div_cnt_q == '0);

      if (phase_if.sync_i) begin
         acc_d     = '0;
         div_cnt_d = phase_if.divider_i;
         value_d   = RAMP_MIN;
         strobe_d  = 1'b1;
      end else if (tick) begin
         acc_d     = acc_sum[W-1:0];
         div_cnt_d = phase_if.divider_i;
         // Offset binary to two's complement: flip the MSB, drop the extension bits.
         value_d   = {~acc_sum[W-1], acc_sum[W-2:N_ACC_EXT]};
         strobe_d  = 1'b1;
         wrap_d    = acc_sum[W];
      end else if (phase_if.enable_i) begin
         div_cnt_d = div_cnt_q - N_DIV'(1);
      end
   end

   // State and output registers; reset clears any pending strobe immediately.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc_q     <= '0;
         div_cnt_q <= '0;
         value_q   <= RAMP_MIN;
         strobe_q  <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         div_cnt_q <= div_cnt_d;
         value_q   <= value_d;
         strobe_q  <= strobe_d;
         wrap_q    <= wrap_d;
      end
   end

   assign phase_if.counter_value_o             = value_q;
   assign phase_if.next_counter_value_strobe_o = strobe_q;
   assign phase_if.wrap_o                      = wrap_q;
endmodule
